adc_stream_emu: RTL and testbench

Synthesizable, parametrised emulator of the serial LVDS output of a multi-channel ADC. It produces per-channel LSB-first serial data and a frame marker on the bit clock. It replaces fixed bench stimulus and is used for in-FPGA loopback and self-test of the ADC deserialiser/DAQ path. It generalises the fixed 16-channel, 12-bit, two-word alternating pattern to configurable channel count and width, and adds ramp, pseudo-random and per-channel programmable modes.

---
 rtl/adc_stream_emu.sv | 166 ++++++++++++++++
 tb/tb_adc_stream_emu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_emu.sv
// Serial multi-channel ADC output emulator: LSB-first per-channel data, frame marker,
// sample strobe and frame counter, with alternate/ramp/PRBS/register pattern modes.
module adc_stream_emu #(
  parameter int NCH = 16,
  parameter int NBITS = 12,
  parameter logic [NBITS-1:0] SAMPLE_A = 12'h106,
  parameter logic [NBITS-1:0] SAMPLE_B = 12'hC59
) (
  input  logic                     CLK,
  input  logic                     RST_B,
  input  logic                     EN,
  input  logic [1:0]               MODE,
  input  logic                     LOAD,
  input  logic [$clog2(NCH)-1:0]   LOAD_CH,
  input  logic [NBITS-1:0]         LOAD_VAL,
  output logic [NCH-1:0]           DOUT,
  output logic                     FRAME,
  output logic                     SAMPLE_STB,
  output logic [15:0]              FCNT
);

  localparam int BCW = $clog2(NBITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);
  localparam logic [BCW-1:0] HALF = BCW'(NBITS / 2);
  localparam logic [31:0] NCH_U = 32'(NCH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_r, state_nxt_s;
  logic load_s, stop_s;

  logic [BCW-1:0]   bit_cnt_r;
  logic [14:0]      lfsr_r;
  logic [15:0]      fcnt_r;
  logic [NCH-1:0]   dout_r;
  logic             frame_r;
  logic             stb_r;
  logic [NBITS-1:0] shreg_r [NCH];
  logic [NBITS-1:0] chreg_r [NCH];
  logic [NBITS-1:0] word_s  [NCH];

  // x^15 + x^14 + 1, shifting left with feedback into bit 0
  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  assign DOUT       = dout_r;
  assign FRAME      = frame_r;
  assign SAMPLE_STB = stb_r;
  assign FCNT       = fcnt_r;

  // State register
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: EN only matters in idle and on the last bit of a frame
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    stop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (EN) begin
          load_s      = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bit_cnt_r == LAST_BIT) begin
          if (EN) begin
            load_s      = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            stop_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Per-channel word for the frame about to be loaded; uses FCNT before its increment
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      word_s[ch] = '0;
      case (MODE)
        2'd0:    word_s[ch] = fcnt_r[0] ? SAMPLE_B : SAMPLE_A;
        2'd1:    word_s[ch] = NBITS'(32'(fcnt_r) + 32'(ch));
        2'd2:    word_s[ch] = NBITS'(32'(lfsr_r) ^ 32'(ch));
        2'd3:    word_s[ch] = chreg_r[ch];
        default: word_s[ch] = '0;
      endcase
    end
  end

  // Frame datapath: load/shift the serialisers, frame marker, strobe, counter, LFSR
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      bit_cnt_r <= '0;
      lfsr_r    <= 15'h7FFF;
      fcnt_r    <= 16'h0000;
      dout_r    <= '0;
      frame_r   <= 1'b0;
      stb_r     <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        shreg_r[ch] <= '0;
      end
    end else if (load_s) begin
      for (int ch = 0; ch < NCH; ch++) begin
        dout_r[ch]  <= word_s[ch][0];
        shreg_r[ch] <= word_s[ch] >> 1;
      end
      bit_cnt_r <= '0;
      frame_r   <= 1'b1;
      stb_r     <= 1'b1;
      fcnt_r    <= fcnt_r + 16'd1;
      lfsr_r    <= (MODE == 2'd2) ? lfsr_step(lfsr_r) : lfsr_r;
    end else if (stop_s) begin
      bit_cnt_r <= '0;
      fcnt_r    <= 16'h0000;
      dout_r    <= '0;
      frame_r   <= 1'b0;
      stb_r     <= 1'b0;
    end else if (state_r == ST_RUN) begin
      for (int ch = 0; ch < NCH; ch++) begin
        dout_r[ch]  <= shreg_r[ch][0];
        shreg_r[ch] <= shreg_r[ch] >> 1;
      end
      bit_cnt_r <= bit_cnt_r + BCW'(1);
      frame_r   <= (bit_cnt_r + BCW'(1)) < HALF;
      stb_r     <= 1'b0;
    end else begin
      dout_r  <= '0;
      frame_r <= 1'b0;
      stb_r   <= 1'b0;
      fcnt_r  <= 16'h0000;
    end
  end

  // Channel registers; a write coincident with a frame load lands after the word was taken
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int ch = 0; ch < NCH; ch++) begin
        chreg_r[ch] <= '0;
      end
    end else if (LOAD && (32'(LOAD_CH) < NCH_U)) begin
      chreg_r[LOAD_CH] <= LOAD_VAL;
    end
  end

endmodule

// File: tb/tb_adc_stream_emu.sv
// Bench for adc_stream_emu: directed frame table, corner sequences, and randomized
// stimulus against a frame-level reference model of the default instance.
module tb_adc_stream_emu;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default instance
  logic        en0 = 1'b0, load0 = 1'b0;
  logic [1:0]  mode0 = 2'd0;
  logic [3:0]  lch0 = 4'd0;
  logic [11:0] lval0 = 12'h000;
  logic [15:0] dout0, fcnt0;
  logic        frame0, stb0;

  // small ramp instance
  logic        en1 = 1'b0, load1 = 1'b0;
  logic [1:0]  md1 = 2'd1;
  logic [1:0]  lch1 = 2'd0;
  logic [7:0]  lval1 = 8'h00;
  logic [3:0]  dout1;
  logic [15:0] fcnt1;
  logic        frame1, stb1;

  // non-power-of-two channel count, for out-of-range LOAD_CH
  logic        en2 = 1'b0, load2 = 1'b0;
  logic [1:0]  md2 = 2'd3;
  logic [2:0]  lch2 = 3'd0;
  logic [3:0]  lval2 = 4'h0;
  logic [5:0]  dout2;
  logic [15:0] fcnt2;
  logic        frame2, stb2;

  adc_stream_emu dut0 (
    .CLK(clk), .RST_B(rst_b), .EN(en0), .MODE(mode0), .LOAD(load0), .LOAD_CH(lch0),
    .LOAD_VAL(lval0), .DOUT(dout0), .FRAME(frame0), .SAMPLE_STB(stb0), .FCNT(fcnt0));

  adc_stream_emu #(.NCH(4), .NBITS(8), .SAMPLE_A(8'hA5), .SAMPLE_B(8'h5A)) dut1 (
    .CLK(clk), .RST_B(rst_b), .EN(en1), .MODE(md1), .LOAD(load1), .LOAD_CH(lch1),
    .LOAD_VAL(lval1), .DOUT(dout1), .FRAME(frame1), .SAMPLE_STB(stb1), .FCNT(fcnt1));

  adc_stream_emu #(.NCH(6), .NBITS(4), .SAMPLE_A(4'h3), .SAMPLE_B(4'hC)) dut2 (
    .CLK(clk), .RST_B(rst_b), .EN(en2), .MODE(md2), .LOAD(load2), .LOAD_CH(lch2),
    .LOAD_VAL(lval2), .DOUT(dout2), .FRAME(frame2), .SAMPLE_STB(stb2), .FCNT(fcnt2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model for dut0 ----------------
  bit        m_run = 1'b0;
  int        m_pos = 0;
  int        m_f = 0;
  int        m_lfsr = 32'h7FFF;
  bit [11:0] m_reg  [16];
  bit [11:0] m_word [16];
  logic [15:0] e_dout;

  function automatic bit [11:0] ref_word(input int md, input int f, input int lfsr,
                                         input int ch, input bit [11:0] rv);
    case (md)
      0:       return (f % 2 == 0) ? 12'h106 : 12'hC59;
      1:       return 12'((f + ch) % 4096);
      2:       return 12'(lfsr ^ ch);
      default: return rv;
    endcase
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_run  <= 1'b0;
      m_pos  <= 0;
      m_f    <= 0;
      m_lfsr <= 32'h7FFF;
      for (int ch = 0; ch < 16; ch++) begin
        m_reg[ch]  <= 12'h000;
        m_word[ch] <= 12'h000;
      end
    end else begin
      if (en0 && (!m_run || m_pos == 11)) begin
        for (int ch = 0; ch < 16; ch++)
          m_word[ch] <= ref_word(int'(mode0), m_f, m_lfsr, ch, m_reg[ch]);
        if (mode0 == 2'd2)
          m_lfsr <= ((m_lfsr << 1) & 32'h7FFF) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1);
        m_f   <= (m_f + 1) % 65536;
        m_pos <= 0;
        m_run <= 1'b1;
      end else if (m_run && m_pos == 11) begin
        m_run <= 1'b0;
        m_pos <= 0;
        m_f   <= 0;
      end else if (m_run) begin
        m_pos <= m_pos + 1;
      end
      if (load0) m_reg[lch0] <= lval0;
    end
  end

  always_comb begin
    e_dout = '0;
    for (int ch = 0; ch < 16; ch++) e_dout[ch] = m_run & m_word[ch][m_pos[3:0]];
  end

  always @(negedge clk) begin
    chk("model_dout", 32'(dout0), 32'(e_dout));
    chk("model_frame", 32'(frame0), 32'(m_run && m_pos < 6));
    chk("model_stb", 32'(stb0), 32'(m_run && m_pos == 0));
    chk("model_fcnt", 32'(fcnt0), 32'(m_f[15:0]));
  end

  // ---------------- directed helpers ----------------
  logic [11:0] cap [16];

  // Called at a negedge just before the load edge; returns at the negedge showing bit 11.
  task automatic run_frame0(input logic [1:0] md, input logic ld, input logic [11:0] ldv,
                            input int drop_at);
    en0 = 1'b1; mode0 = md; load0 = ld; lch0 = 4'd5; lval0 = ldv;
    @(posedge clk);
    for (int b = 0; b < 12; b++) begin
      @(negedge clk);
      if (b == 0) load0 = 1'b0;
      if (b == drop_at) en0 = 1'b0;
      for (int ch = 0; ch < 16; ch++) cap[ch][b] = dout0[ch];
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        ld;
    logic [11:0] ld_val;
    logic [11:0] w0, w1, w5;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] cap1 [4];
  logic [3:0] cap2 [6];

  initial begin
    tbl[0] = '{2'd0, 1'b0, 12'h000, 12'h106, 12'h106, 12'h106, 16'd1};
    tbl[1] = '{2'd0, 1'b0, 12'h000, 12'hC59, 12'hC59, 12'hC59, 16'd2};
    tbl[2] = '{2'd1, 1'b0, 12'h000, 12'h002, 12'h003, 12'h007, 16'd3};
    tbl[3] = '{2'd3, 1'b1, 12'h123, 12'h000, 12'h000, 12'hABC, 16'd4};
    tbl[4] = '{2'd3, 1'b0, 12'h000, 12'h000, 12'h000, 12'h123, 16'd5};
    tbl[5] = '{2'd2, 1'b0, 12'h000, 12'hFFF, 12'hFFE, 12'hFFA, 16'd6};
    tbl[6] = '{2'd2, 1'b0, 12'h000, 12'hFFE, 12'hFFF, 12'hFFB, 16'd7};
    tbl[7] = '{2'd0, 1'b0, 12'h000, 12'hC59, 12'hC59, 12'hC59, 16'd8};

    #1 rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dout", 32'(dout0), 32'h0);
    chk("reset_frame", 32'(frame0), 32'h0);
    chk("reset_stb", 32'(stb0), 32'h0);
    chk("reset_fcnt", 32'(fcnt0), 32'h0);
    rst_b = 1'b1;
    @(negedge clk);
    load0 = 1'b1; lch0 = 4'd5; lval0 = 12'hABC;
    @(negedge clk);
    load0 = 1'b0;
    chk("idle_fcnt", 32'(fcnt0), 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_frame0(tbl[i].mode, tbl[i].ld, tbl[i].ld_val, -1);
      chk("tbl_ch0", 32'(cap[0]), 32'(tbl[i].w0));
      chk("tbl_ch1", 32'(cap[1]), 32'(tbl[i].w1));
      chk("tbl_ch5", 32'(cap[5]), 32'(tbl[i].w5));
      chk("tbl_fcnt", 32'(fcnt0), 32'(tbl[i].fc));
    end

    // EN dropped at bit 3: frame completes, then idle
    run_frame0(2'd0, 1'b0, 12'h000, 3);
    chk("drop_word", 32'(cap[0]), 32'h106);
    @(negedge clk);
    chk("drop_dout", 32'(dout0), 32'h0);
    chk("drop_frame", 32'(frame0), 32'h0);
    chk("drop_fcnt", 32'(fcnt0), 32'h0);
    run_frame0(2'd0, 1'b0, 12'h000, -1);
    chk("restart_word", 32'(cap[3]), 32'h106);
    chk("restart_fcnt", 32'(fcnt0), 32'h1);

    // reset pulsed at bit 7 of a running frame
    @(posedge clk);
    repeat (7) @(posedge clk);
    #2;
    chk("prerst_fcnt", 32'(fcnt0), 32'h2);
    rst_b = 1'b0;
    #1;
    chk("async_dout", 32'(dout0), 32'h0);
    chk("async_frame", 32'(frame0), 32'h0);
    chk("async_fcnt", 32'(fcnt0), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    run_frame0(2'd2, 1'b0, 12'h000, -1);
    chk("reseed_ch0", 32'(cap[0]), 32'hFFF);
    chk("reseed_fcnt", 32'(fcnt0), 32'h1);
    run_frame0(2'd3, 1'b0, 12'h000, 0);
    chk("regclr_ch5", 32'(cap[5]), 32'h000);
    repeat (3) @(negedge clk);

    // out-of-range LOAD_CH on a 6-channel instance
    load2 = 1'b1; lch2 = 3'd6; lval2 = 4'hF;
    @(negedge clk); lch2 = 3'd7; lval2 = 4'hA;
    @(negedge clk); lch2 = 3'd2; lval2 = 4'h9;
    @(negedge clk); load2 = 1'b0; md2 = 2'd3; en2 = 1'b1;
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      en2 = 1'b0;
      for (int ch = 0; ch < 6; ch++) cap2[ch][b] = dout2[ch];
    end
    for (int ch = 0; ch < 6; ch++) chk("ldch_word", 32'(cap2[ch]), (ch == 2) ? 32'h9 : 32'h0);

    // ramp wrap on NCH=4, NBITS=8
    md1 = 2'd1; en1 = 1'b1;
    @(posedge clk);
    for (int fr = 0; fr < 256; fr++) begin
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        if (fr == 255) en1 = 1'b0;
        for (int ch = 0; ch < 4; ch++) cap1[ch][b] = dout1[ch];
      end
      for (int ch = 0; ch < 4; ch++) chk("d1_ramp", 32'(cap1[ch]), 32'((fr + ch) % 256));
    end
    chk("d1_fcnt", 32'(fcnt1), 32'd256);

    // randomized run on the default instance, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en0   = ($urandom_range(0, 9) < 8);
      mode0 = 2'($urandom_range(0, 3));
      load0 = ($urandom_range(0, 4) == 0);
      lch0  = 4'($urandom_range(0, 15));
      lval0 = 12'($urandom);
    end
    @(negedge clk);
    en0 = 1'b0; load0 = 1'b0;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
